// File: rtl/dg0045_fetch.sv
// dg0045_fetch: instruction-fetch stage of the DG0045 4-bit core.
// Runs the 8-phase machine cycle and drives the program counter onto the
// multiplexed PC_HL pins. It samples ROM bytes, assembles one- and two-byte
// instructions, and applies branch/return redirects at the cycle boundary.
//
// Optional feature: define DG0045_SKIP_EN to enable instruction skipping
// via skip_req. Without it, skip_req is ignored.
//
// state | meaning
// ------+---------------------------------------------------------------
// S_OP  | next ROM capture is an opcode byte (goes to ins_op)
// S_ARG | long opcode seen; next ROM capture is its argument (ins_arg)

module dg0045_fetch #(
  parameter int PIN_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [7:0]           rom_data,
  input  logic                 br_load,
  input  logic [2*PIN_W-1:0]   br_addr,
  input  logic                 skip_req,
  output logic [PIN_W-1:0]     pc_hl,
  output logic                 pc_mux,
  output logic [2:0]           phase,
  output logic [2*PIN_W-1:0]   pc,
  output logic                 ins_valid,
  output logic [7:0]           ins_op,
  output logic [7:0]           ins_arg
);

  localparam int PC_W = 2 * PIN_W;

  localparam logic [0:0] S_OP  = 1'b0;
  localparam logic [0:0] S_ARG = 1'b1;

  localparam logic [2:0] PH_CAPTURE = 3'd5;
  localparam logic [2:0] PH_DECIDE  = 3'd6;
  localparam logic [2:0] PH_LAST    = 3'd7;

  logic [0:0]      state;
  logic            br_pend;
  logic [PC_W-1:0] br_tgt;

  logic [2:0]      phase_nxt;
  logic            cyc_end;
  logic            redirect;
  logic [PC_W-1:0] redir_addr;
  logic [PC_W-1:0] pc_nxt;
  logic            deliver;
  logic            skip_act;

  // Next-phase, next-PC and decision terms shared by the registers below.
  // A br_load on the last-phase edge itself takes priority over a pending one.
  always_comb begin
    phase_nxt  = phase + 3'd1;
    cyc_end    = (phase == PH_LAST);
    redirect   = cyc_end && (br_load || br_pend);
    redir_addr = br_load ? br_addr : br_tgt;
    pc_nxt     = pc;
    if (cyc_end) begin
      if (redirect) begin
        pc_nxt = redir_addr;
      end else begin
        pc_nxt = pc + {{(PC_W-1){1'b0}}, 1'b1};
      end
    end
    // An instruction completes on the decide edge unless the opcode just
    // captured starts a two-byte JMP/CALL-class instruction.
    deliver = (phase == PH_DECIDE) &&
              ((state == S_ARG) || (ins_op[7:6] != 2'b11));
  end

  // Phase counter, PC, pin drivers, instruction assembly and state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= 3'd0;
      pc        <= '0;
      pc_hl     <= '0;
      pc_mux    <= 1'b0;
      ins_valid <= 1'b0;
      ins_op    <= 8'h00;
      ins_arg   <= 8'h00;
      state     <= S_OP;
    end else if (ena) begin
      phase  <= phase_nxt;
      pc     <= pc_nxt;
      // The pins present the half that belongs to the phase being entered.
      pc_mux <= (phase_nxt >= 3'd2);
      if (phase_nxt < 3'd2) begin
        pc_hl <= pc_nxt[PIN_W-1:0];
      end else begin
        pc_hl <= pc_nxt[PC_W-1:PIN_W];
      end

      if (phase == PH_CAPTURE) begin
        if (state == S_OP) begin
          ins_op <= rom_data;
        end else begin
          ins_arg <= rom_data;
        end
      end

      if (phase == PH_DECIDE) begin
        if (deliver) begin
          ins_valid <= !skip_act;
          state     <= S_OP;
        end else begin
          state     <= S_ARG;
        end
      end

      if (cyc_end) begin
        ins_valid <= 1'b0;
        // A redirect abandons any half-fetched long instruction.
        if (redirect) begin
          state <= S_OP;
        end
      end
    end
  end

  // Redirect request latch: the last request before the cycle boundary wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_pend <= 1'b0;
      br_tgt  <= '0;
    end else if (ena) begin
      if (cyc_end) begin
        br_pend <= 1'b0;
      end else if (br_load) begin
        br_pend <= 1'b1;
        br_tgt  <= br_addr;
      end
    end
  end

`ifdef DG0045_SKIP_EN
  logic skip_flag;

  // Skip flag: armed by skip_req, consumed by the next completed
  // instruction, and dropped by any redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_flag <= 1'b0;
    end else if (ena) begin
      if (redirect) begin
        skip_flag <= 1'b0;
      end else if (deliver) begin
        skip_flag <= skip_req;
      end else if (skip_req) begin
        skip_flag <= 1'b1;
      end
    end
  end

  assign skip_act = skip_flag;
`else
  logic unused_skip;

  assign skip_act    = 1'b0;
  assign unused_skip = skip_req;
`endif

endmodule

// File: tb/tb_dg0045_fetch.sv
// tb_dg0045_fetch: directed bench for dg0045_fetch.
// An external ROM is modelled from the pins: the low PC half is latched
// while pc_mux=0, and the byte is looked up once the high half is shown.
// Runs with or without DG0045_SKIP_EN.

module tb_dg0045_fetch;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] rom_data;
  logic       br_load;
  logic [9:0] br_addr;
  logic       skip_req;
  logic [4:0] pc_hl;
  logic       pc_mux;
  logic [2:0] phase;
  logic [9:0] pc;
  logic       ins_valid;
  logic [7:0] ins_op;
  logic [7:0] ins_arg;

  logic [7:0] rom [0:1023];
  logic [4:0] lo_q = 5'd0;

  int n_chk  = 0;
  int n_pass = 0;

  dg0045_fetch #(.PIN_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .rom_data  (rom_data),
    .br_load   (br_load),
    .br_addr   (br_addr),
    .skip_req  (skip_req),
    .pc_hl     (pc_hl),
    .pc_mux    (pc_mux),
    .phase     (phase),
    .pc        (pc),
    .ins_valid (ins_valid),
    .ins_op    (ins_op),
    .ins_arg   (ins_arg)
  );

  always #5 clk = ~clk;

  // External address latch for the low PC half.
  always @(negedge clk) begin
    if (!pc_mux) lo_q = pc_hl;
  end

  assign rom_data = rom[{(pc_mux ? pc_hl : 5'd0), lo_q}];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ena      = 1'b1;
    br_load  = 1'b0;
    br_addr  = 10'd0;
    skip_req = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
  endtask

  initial begin
    rst      = 1'b1;
    ena      = 1'b1;
    br_load  = 1'b0;
    br_addr  = 10'd0;
    skip_req = 1'b0;
    clear_rom();
    step(2);

    // Reset state
    check("rst_phase", phase, 0);
    check("rst_pc", pc, 0);
    check("rst_pc_hl", pc_hl, 0);
    check("rst_pc_mux", pc_mux, 0);
    check("rst_valid", ins_valid, 0);
    check("rst_op", ins_op, 8'h00);
    check("rst_arg", ins_arg, 8'h00);

    // Short instructions, one per machine cycle
    rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'h03;
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      step(1);
      check("short_phase", phase, e % 8);
      check("short_mux", pc_mux, ((e % 8) >= 2) ? 1 : 0);
      check("short_hl", pc_hl, ((e % 8) < 2) ? (e / 8) : 0);
      check("short_valid", ins_valid, (e == 7 || e == 15 || e == 23) ? 1 : 0);
      if (e == 7)  check("short_op0", ins_op, 8'h01);
      if (e == 15) check("short_op1", ins_op, 8'h02);
      if (e == 23) check("short_op2", ins_op, 8'h03);
    end

    // Long instruction followed by a short one
    clear_rom();
    rom[0] = 8'hC5; rom[1] = 8'h3A; rom[2] = 8'h10;
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      step(1);
      check("long_valid", ins_valid, (e == 15 || e == 23) ? 1 : 0);
      if (e == 15) begin
        check("long_op", ins_op, 8'hC5);
        check("long_arg", ins_arg, 8'h3A);
      end
      if (e == 16) check("long_pc", pc, 10'h002);
      if (e == 23) check("long_next_op", ins_op, 8'h10);
    end

    // Redirect requested in phase 3, applied at the cycle boundary
    clear_rom();
    rom[0] = 8'h01; rom[10'h2E7] = 8'h5A;
    do_reset();
    step(3);
    br_load = 1'b1; br_addr = 10'h2E7;
    step(1);
    br_load = 1'b0; br_addr = 10'h000;
    step(3);
    check("br_old_valid", ins_valid, 1);
    check("br_old_op", ins_op, 8'h01);
    step(1);
    check("br_pc", pc, 10'h2E7);
    check("br_hl_ph0", pc_hl, 5'h07);
    check("br_mux_ph0", pc_mux, 0);
    step(1);
    check("br_hl_ph1", pc_hl, 5'h07);
    step(1);
    check("br_hl_ph2", pc_hl, 5'h17);
    check("br_mux_ph2", pc_mux, 1);
    step(5);
    check("br_new_valid", ins_valid, 1);
    check("br_new_op", ins_op, 8'h5A);
    step(1);
    check("br_pc_inc", pc, 10'h2E8);

    // Redirect on the boundary edge itself to 0x3FF, then PC wraps
    clear_rom();
    rom[0] = 8'h01; rom[10'h3FF] = 8'h22;
    do_reset();
    step(7);
    br_load = 1'b1; br_addr = 10'h3FF;
    step(1);
    br_load = 1'b0;
    check("wrap_pc_set", pc, 10'h3FF);
    check("wrap_hl", pc_hl, 5'h1F);
    step(7);
    check("wrap_valid", ins_valid, 1);
    check("wrap_op", ins_op, 8'h22);
    step(1);
    check("wrap_pc", pc, 10'h000);
    check("wrap_hl0", pc_hl, 5'h00);

    // Redirect while waiting for a long opcode's argument aborts it
    clear_rom();
    rom[0] = 8'hC5; rom[1] = 8'h3A; rom[10'h100] = 8'h33;
    do_reset();
    step(7);
    check("abort_no_valid1", ins_valid, 0);
    br_load = 1'b1; br_addr = 10'h100;
    step(1);
    br_load = 1'b0;
    check("abort_pc", pc, 10'h100);
    step(6);
    check("abort_no_valid2", ins_valid, 0);
    step(1);
    check("abort_valid", ins_valid, 1);
    check("abort_op", ins_op, 8'h33);
    check("abort_arg", ins_arg, 8'h00);

    // Clock enable low in phase 7 freezes everything
    clear_rom();
    rom[0] = 8'h01;
    do_reset();
    step(7);
    check("ena_valid_pre", ins_valid, 1);
    ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("ena_hold_valid", ins_valid, 1);
      check("ena_hold_phase", phase, 7);
      check("ena_hold_pc", pc, 0);
    end
    ena = 1'b1;
    step(1);
    check("ena_resume_valid", ins_valid, 0);
    check("ena_resume_phase", phase, 0);
    check("ena_resume_pc", pc, 1);

    // Synchronous reset in phase 4 wins even with ena low
    step(4);
    check("mid_pre_mux", pc_mux, 1);
    check("mid_pre_op", ins_op, 8'h01);
    rst = 1'b1; ena = 1'b0;
    step(1);
    check("mid_rst_phase", phase, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_mux", pc_mux, 0);
    check("mid_rst_hl", pc_hl, 0);
    check("mid_rst_valid", ins_valid, 0);
    check("mid_rst_op", ins_op, 8'h00);
    rst = 1'b0; ena = 1'b1;

    // Skip request during a delivered instruction's phase 7
    clear_rom();
    rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'h03;
    do_reset();
    step(7);
    check("skip_first_valid", ins_valid, 1);
    skip_req = 1'b1;
    step(1);
    skip_req = 1'b0;
    step(7);
`ifdef DG0045_SKIP_EN
    check("skip_suppressed", ins_valid, 0);
`else
    check("skip_ignored", ins_valid, 1);
`endif
    check("skip_op_fetched", ins_op, 8'h02);
    step(1);
    check("skip_pc", pc, 10'h002);
    step(7);
    check("skip_after_valid", ins_valid, 1);
    check("skip_after_op", ins_op, 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
